// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative RV32M multiply/divide unit, one result bit per cycle
// The first iteration runs on the acceptance edge, so CALC holds for WIDTH-1 edges.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam int W2 = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 2);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] out_q, out_d;

  // Shift-add: multiplier sits in the low half and drains out to the right.
  function automatic logic [W2-1:0] mul_step(input logic [W2-1:0] acc,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, b} : {(WIDTH+1){1'b0}});
    return {sum, acc[WIDTH-1:1]};
  endfunction

  function automatic logic [W2-1:0] div_step(input logic [WIDTH-1:0] rem,
                                             input logic [WIDTH-1:0] quo,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sh;
    sh = {rem, quo[WIDTH-1]};
    if (sh >= {1'b0, b}) begin
      return {WIDTH'(sh - {1'b0, b}), quo[WIDTH-2:0], 1'b1};
    end
    return {sh[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
  endfunction

  logic             sgn1_in, sgn2_in, div_zero, div_ovf, special;
  logic [WIDTH-1:0] mag1, mag2, special_res;
  logic [W2-1:0]    mul_init, div_init, mul_calc, div_calc;

  assign sgn1_in = in1[WIDTH-1] & (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
  assign sgn2_in = in2[WIDTH-1] & (op == OP_MULH || op == OP_DIV || op == OP_REM);
  assign mag1 = sgn1_in ? (~in1 + WIDTH'(1)) : in1;
  assign mag2 = sgn2_in ? (~in2 + WIDTH'(1)) : in2;

  assign div_zero = op[2] & (in2 == '0);
  assign div_ovf  = (op == OP_DIV || op == OP_REM) & (in1 == MIN_NEG) & (&in2);
  assign special  = div_zero | div_ovf;
  assign special_res = div_zero ? (op[1] ? in1 : '1) : (op[1] ? '0 : in1);

  assign mul_init = mul_step({{WIDTH{1'b0}}, mag2}, mag1);
  assign div_init = div_step('0, mag1, mag2);
  assign mul_calc = mul_step(acc_q, b_q);
  assign div_calc = div_step(rem_q, quo_q, b_q);

  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix, calc_res;

  always_comb begin
    prod_fix = neg_q ? (~mul_calc + W2'(1)) : mul_calc;
    quo_fix  = neg_q ? (~div_calc[WIDTH-1:0] + WIDTH'(1)) : div_calc[WIDTH-1:0];
    rem_fix  = neg_q ? (~div_calc[W2-1:WIDTH] + WIDTH'(1)) : div_calc[W2-1:WIDTH];
    if (op_q[2]) begin
      calc_res = op_q[1] ? rem_fix : quo_fix;
    end else begin
      calc_res = (op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[W2-1:WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    out_d   = out_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_d  = op;
            cnt_d = '0;
            neg_d = (op[2] & op[1]) ? sgn1_in : (sgn1_in ^ sgn2_in);
            b_d   = op[2] ? mag2 : mag1;
            acc_d = mul_init;
            {rem_d, quo_d} = div_init;
            if (special) begin
              out_d   = special_res;
              state_d = ST_DONE;
            end else begin
              state_d = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (op_q[2]) begin
            {rem_d, quo_d} = div_calc;
          end else begin
            acc_d = mul_calc;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            out_d   = calc_res;
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      b_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out       = out_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - randomized and directed self-checking bench for mdu_iter
// Expected results come from 64-bit integer arithmetic; timing from an edge-count model.
module tb_mdu_iter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dut_out;

  int n_total = 0;
  int n_pass  = 0;

  mdu_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in1       (in1),
    .in2       (in2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dut_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int si, sj;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    si = $signed(a);
    sj = $signed(b);
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(si / sj);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(si % sj);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit ref_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Timing model: edges remaining until the result appears, and the held result.
  bit          m_busy = 0;
  bit          m_have = 0;
  int          m_left = 0;
  logic [31:0] m_pend = 0;
  logic [31:0] m_out  = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_have = 0; m_left = 0; m_out = 0;
    end
    check("in_ready", in_ready, !(m_busy || m_have));
    check("out_valid", out_valid, m_have);
    check("out", dut_out, m_out);
    if (rst_n) begin
      if (flush) begin
        m_busy = 0; m_have = 0;
      end else if (m_have) begin
        if (out_ready) m_have = 0;
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_have = 1; m_out = m_pend;
        end
      end else if (in_valid) begin
        if (ref_special(op, in1, in2)) begin
          m_have = 1; m_out = ref_result(op, in1, in2);
        end else begin
          m_busy = 1; m_left = 31; m_pend = ref_result(op, in1, in2);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    check("accept_ready", in_ready, 1);
    in_valid = 1; op = o; in1 = a; in2 = b;
    tick();
    in_valid = 0; op = 3'($urandom); in1 = $urandom; in2 = $urandom;
  endtask

  task automatic run_vec(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input int lat);
    int n;
    check("model_pin", ref_result(o, a, b), e);
    accept(o, a, b);
    n = 1;
    while (!out_valid && n < 64) begin tick(); n++; end
    check("latency", n, lat);
    check("result", dut_out, e);
    out_ready = 1;
    tick();
    out_ready = 0;
    check("ready_after_xfer", in_ready, 1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      4: return 32'd0 - 32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen;
    rst_n = 0; in_valid = 0; op = 0; in1 = 0; in2 = 0; flush = 0; out_ready = 0;
    tick(); tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", dut_out, 0);
    rst_n = 1;
    tick();

    run_vec(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32);
    run_vec(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32);
    run_vec(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);
    run_vec(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
    run_vec(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
    run_vec(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
    run_vec(3'd5, 32'hFFFF_FFFE, 32'd3, 32'h5555_5554, 32);
    run_vec(3'd7, 32'd100, 32'd7, 32'd2, 32);
    run_vec(3'd5, 32'd12345, 32'd0, 32'hFFFF_FFFF, 1);
    run_vec(3'd6, 32'd5, 32'd0, 32'd5, 1);
    run_vec(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_vec(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Result held with the consumer stalled.
    accept(3'd0, 32'd1000, 32'd1000);
    seen = 0;
    while (!out_valid && seen < 64) begin tick(); seen++; end
    repeat (10) tick();
    check("hold_out", dut_out, 32'd1000000);
    check("hold_valid", out_valid, 1);
    check("hold_in_ready", in_ready, 0);
    out_ready = 1;
    tick();
    out_ready = 0;
    check("hold_release_ready", in_ready, 1);

    // Flush after ten CALC iterations; no result may follow.
    accept(3'd0, 32'h1234, 32'h5678);
    repeat (9) tick();
    flush = 1;
    tick();
    flush = 0;
    check("flush_in_ready", in_ready, 1);
    check("flush_out_valid", out_valid, 0);
    seen = 0;
    repeat (40) begin tick(); if (out_valid) seen++; end
    check("flush_no_result", seen, 0);
    run_vec(3'd0, 32'd3, 32'd4, 32'd12, 32);

    // A request alongside flush is ignored.
    in_valid = 1; flush = 1; op = 3'd0; in1 = 32'd9; in2 = 32'd9;
    tick();
    in_valid = 0; flush = 0;
    check("flush_blocks_accept", in_ready, 1);

    // Asynchronous reset mid-CALC.
    accept(3'd0, 32'd77, 32'd88);
    repeat (5) tick();
    rst_n = 0;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_out_valid", out_valid, 0);
    check("arst_out", dut_out, 0);
    tick(); tick();
    rst_n = 1;
    tick();
    run_vec(3'd0, 32'd3, 32'd4, 32'd12, 32);

    for (int c = 0; c < 8000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = 3'($urandom_range(0, 7));
      in1       = pick();
      in2       = pick();
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 99) < 2);
      tick();
    end
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (40) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide unit: the sequential companion to the single-cycle integer ALU. It executes the RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) over a configurable operand width. It computes one bit per cycle behind a valid/ready handshake on both input and output. The execute stage issues to it and stalls on `in_ready`/`out_valid`.

## Interface
- `WIDTH`, 32: operand and result width in bits; must be ≥ 4.
- `CNT_W`, $clog2(WIDTH): width of the internal bit counter.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operation request.
- `in_ready` output 1: unit can accept a request.
- `op` input 3: RV32M funct3 encoding. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `in1` input WIDTH: rs1 operand.
- `in2` input WIDTH: rs2 operand.
- `flush` input 1: synchronous abort of the current operation.
- `out_valid` output 1: `out` holds a completed result.
- `out_ready` input 1: consumer accepts the result.
- `out` output WIDTH: result.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - CALC: WIDTH iterations.
  - DONE: `out_valid`=1.
- Transitions:
  - IDLE→CALC when `in_valid`. Operands, op and sign flags are latched, and the counter is cleared.
  - IDLE→DONE instead on a divide special case.
  - CALC→DONE when the counter reaches WIDTH-1.
  - DONE→IDLE when `out_ready`.
  - Any state→IDLE when `flush`. Flush overrides all other events, and any pending result is discarded.
- Signedness:
  - Signed operands are converted to magnitudes at latch time.
  - MULHSU: `in1` is signed, `in2` is unsigned.
  - Result sign:
    - Product: sign(in1) XOR sign(in2).
    - Quotient: sign(in1) XOR sign(in2).
    - Remainder: sign(in1).
  - The sign fix-up (two's-complement negate) is applied on the final CALC edge.
- Multiply: unsigned shift-add into a 2·WIDTH accumulator, one multiplier bit per cycle.
  - MUL returns the low WIDTH bits.
  - MULH, MULHSU and MULHU return the high WIDTH bits of the correctly signed 2·WIDTH product.
- Divide: restoring division, one quotient bit per cycle, with a WIDTH+1 bit partial remainder.
- Special cases, detected in IDLE and taking no CALC cycles:
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → `in1`.
  - Signed overflow, DIV/REM with `in1` = 1 followed by zeros and `in2` = all ones: DIV → `in1`; REM → 0.
- All arithmetic is modulo 2^WIDTH. No exceptions or flags are raised.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out`=0, counter 0.
- Acceptance: the rising edge where `in_valid` && `in_ready`.
- Normal latency: `out_valid` rises WIDTH edges after acceptance, i.e. 32 cycles at the default width.
- Special-case latency: `out_valid` rises 1 edge after acceptance.
- `in_ready` is 0 in CALC and DONE. No new request is accepted until the cycle after the result is consumed; there is no overlap.
- Output hold: `out` and `out_valid` stay stable while `out_valid` && !`out_ready`.
- `out` keeps its last value in IDLE; it is not cleared.
- Result transfer: the edge where `out_valid` && `out_ready`. The state returns to IDLE with `in_ready`=1 in the next cycle.
- `flush`:
  - Takes effect at the sampling edge.
  - The next cycle has `in_ready`=1 and `out_valid`=0.
  - A request presented in the same cycle as `flush` is not accepted.
- Asynchronous reset mid-operation: immediate return to the reset values. No result is produced for the aborted operation.
- `op`, `in1` and `in2` are ignored except at the acceptance edge.

## Test plan
- MUL, in1=7, in2=-3 (0xFFFFFFFD) → `out`=0xFFFFFFEB, `out_valid` exactly 32 cycles after acceptance, `in_ready`=0 throughout.
- MULH, 0x80000000 × 0x80000000 → 0x40000000. MULHU, 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU, -1 × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV, -7 / 2 → 0xFFFFFFFD (-3). REM, -7 % 2 → 0xFFFFFFFF (-1). DIVU, 0xFFFFFFFE / 3 → 0x55555554. REMU, 100 % 7 → 2.
- Divide special cases:
  - DIVU x/0 → 0xFFFFFFFF; REM 5%0 → 5.
  - DIV 0x80000000/-1 → 0x80000000; REM same operands → 0.
  - Each with `out_valid` 1 cycle after acceptance.
- Hold `out_ready`=0 for 10 cycles after completion → `out` stable, `in_ready`=0. Release it → transfer, then `in_ready`=1 the next cycle.
- `flush` at CALC iteration 10 → next cycle IDLE, `out_valid` never asserts. A new MUL 3×4 then returns 12. Repeat with `rst_n` pulsed low mid-CALC → reset values immediately.
